// File: rtl/spk_out_fifo.sv
// Spike output FIFO: buffers fired spikes as {dst, neuid} and emits them to the router.
// Ports: clk/rst_n, soma_spk_vld/soma_spk/config_spk_out_neuid/config_dst in, tik,
//   spk_out_config_full, spk_out_vld/rdy/data/empty/ovf, spk_cnt (SPK_OUT_CNT_EN only).
module spk_out_fifo #(
  parameter int SW     = 24,
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int MARGIN = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soma_spk_vld,
  input  logic          soma_spk,
  input  logic [SW-1:0] config_spk_out_neuid,
  input  logic [DW-1:0] config_dst,
  input  logic          tik,
  output logic          spk_out_config_full,
  output logic          spk_out_vld,
  input  logic          spk_out_rdy,
  output logic [DW+SW-1:0] spk_out_data,
  output logic          spk_out_empty,
`ifdef SPK_OUT_CNT_EN
  output logic          spk_out_ovf,
  output logic [CW-1:0] spk_cnt
`else
  output logic          spk_out_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + SW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR_C   = (AW+1)'(DEPTH - MARGIN);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          wr, rd, wr_acc;
  logic          full_q, ovf_q;

  assign wr = soma_spk_vld & soma_spk;
  assign rd = spk_out_vld & spk_out_rdy;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_acc = wr & ((count < DEPTH_C) | rd);

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (wr_acc) state_d = S_HOLD;
      S_HOLD:  if (rd && count == ONE_C && !wr_acc) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_nxt;
      full_q  <= (count_nxt >= THR_C);
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd)     rd_ptr <= rd_ptr + 1'b1;
      if (wr && !wr_acc) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {config_dst, config_spk_out_neuid};
  end

  assign spk_out_vld         = (state_q == S_HOLD);
  assign spk_out_data        = mem[rd_ptr];
  assign spk_out_empty       = (count == '0);
  assign spk_out_config_full = full_q;
  assign spk_out_ovf         = ovf_q;

`ifdef SPK_OUT_CNT_EN
  logic [CW-1:0] cnt_q, cnt_inc;

  assign cnt_inc = (wr_acc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      spk_cnt <= '0;
    end else if (tik) begin
      spk_cnt <= cnt_inc;
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_inc;
    end
  end
`else
  logic unused_tik;
  assign unused_tik = tik;
`endif

endmodule

// File: tb/tb_spk_out_fifo.sv
// Testbench for spk_out_fifo: directed scenarios plus random traffic
// checked against a queue-based model.
module tb_spk_out_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soma_spk_vld = 1'b0;
  logic        soma_spk = 1'b0;
  logic [23:0] config_spk_out_neuid = '0;
  logic [7:0]  config_dst = '0;
  logic        tik = 1'b0;
  logic        spk_out_config_full;
  logic        spk_out_vld;
  logic        spk_out_rdy = 1'b0;
  logic [31:0] spk_out_data;
  logic        spk_out_empty;
  logic        spk_out_ovf;
`ifdef SPK_OUT_CNT_EN
  logic [15:0] spk_cnt;
`endif

  spk_out_fifo dut (
    .clk(clk),
    .rst_n(rst_n),
    .soma_spk_vld(soma_spk_vld),
    .soma_spk(soma_spk),
    .config_spk_out_neuid(config_spk_out_neuid),
    .config_dst(config_dst),
    .tik(tik),
    .spk_out_config_full(spk_out_config_full),
    .spk_out_vld(spk_out_vld),
    .spk_out_rdy(spk_out_rdy),
    .spk_out_data(spk_out_data),
    .spk_out_empty(spk_out_empty),
`ifdef SPK_OUT_CNT_EN
    .spk_out_ovf(spk_out_ovf),
    .spk_cnt(spk_cnt)
`else
    .spk_out_ovf(spk_out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_m[$];
  logic        ovf_m;
  logic        full_m;
  int          cnt_m;
  int          spk_cnt_m;
  logic [23:0] outq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("vld", 64'(spk_out_vld), 64'(q_m.size() != 0));
    chk("empty", 64'(spk_out_empty), 64'(q_m.size() == 0));
    chk("full", 64'(spk_out_config_full), 64'(full_m));
    chk("ovf", 64'(spk_out_ovf), 64'(ovf_m));
    if (q_m.size() != 0) chk("data", 64'(spk_out_data), 64'(q_m[0]));
`ifdef SPK_OUT_CNT_EN
    chk("spk_cnt", 64'(spk_cnt), 64'(spk_cnt_m));
`endif
  endtask

  task automatic model_clear();
    q_m.delete();
    ovf_m = 1'b0;
    full_m = 1'b0;
    cnt_m = 0;
    spk_cnt_m = 0;
  endtask

  // Called at negedge: drive, update model, advance one cycle, check.
  task automatic step(input logic w, input logic r, input logic [23:0] id,
                      input logic [7:0] dst, input logic tk);
    logic rd_m, acc_m;
    soma_spk_vld = w | ($urandom_range(0, 3) == 0);
    soma_spk = w;
    config_spk_out_neuid = id;
    config_dst = dst;
    spk_out_rdy = r;
    tik = tk;
    if (spk_out_vld && r) outq.push_back(spk_out_data[23:0]);
    rd_m = (q_m.size() != 0) && r;
    acc_m = w && (q_m.size() < 16 || rd_m);
    if (rd_m) void'(q_m.pop_front());
    if (acc_m) q_m.push_back({dst, id});
    if (w && !acc_m) ovf_m = 1'b1;
    full_m = (q_m.size() >= 12);
    if (acc_m && cnt_m < 65535) cnt_m++;
    if (tk) begin
      spk_cnt_m = cnt_m;
      cnt_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    soma_spk_vld = 1'b0;
    soma_spk = 1'b0;
    spk_out_rdy = 1'b0;
    tik = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // reset state
    chk("rst_vld", 64'(spk_out_vld), 64'(0));
    chk("rst_empty", 64'(spk_out_empty), 64'(1));
    chk("rst_full", 64'(spk_out_config_full), 64'(0));
    chk("rst_ovf", 64'(spk_out_ovf), 64'(0));
    do_reset();

    // single write, pop
    step(1'b1, 1'b0, 24'h010203, 8'h5A, 1'b0);
    chk("t1_vld", 64'(spk_out_vld), 64'(1));
    chk("t1_data", 64'(spk_out_data), 64'h5A010203);
    step(1'b0, 1'b1, 24'h0, 8'h0, 1'b0);
    chk("t1_empty", 64'(spk_out_empty), 64'(1));

    // fill with rdy low; full after 12th, overflow on 17th
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 24'(i), 8'h11, 1'b0);
      chk("t2_full", 64'(spk_out_config_full), 64'(i == 11));
    end
    for (int i = 12; i < 16; i++) step(1'b1, 1'b0, 24'(i), 8'h11, 1'b0);
    chk("t2_noovf", 64'(spk_out_ovf), 64'(0));
    step(1'b1, 1'b0, 24'hDEAD, 8'h11, 1'b0);
    chk("t2_ovf", 64'(spk_out_ovf), 64'(1));
    chk("t2_head", 64'(spk_out_data), 64'h11000000);

    // full + simultaneous read and write
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 24'(i), 8'h22, 1'b0);
    step(1'b1, 1'b1, 24'h0000AA, 8'h22, 1'b0);
    chk("t3_noovf", 64'(spk_out_ovf), 64'(0));
    chk("t3_full", 64'(spk_out_config_full), 64'(1));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 24'h0, 8'h0, 1'b0);
    chk("t3_empty", 64'(spk_out_empty), 64'(1));

    // ordered stream with random rdy
    do_reset();
    outq.delete();
    begin
      int n;
      int cyc;
      n = 0;
      cyc = 0;
      while (outq.size() < 20 && cyc < 400) begin
        logic w;
        w = (n < 20) && ($urandom_range(0, 2) != 0);
        step(w, 1'($urandom_range(0, 1)), 24'(n), 8'h33, 1'b0);
        if (w) n++;
        cyc++;
      end
      chk("t4_count", 64'(outq.size()), 64'(20));
      for (int i = 0; i < outq.size(); i++)
        chk("t4_order", 64'(outq[i]), 64'(i));
    end

    // async reset with 5 queued
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'(i), 8'h44, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_vld", 64'(spk_out_vld), 64'(0));
    chk("t5_empty", 64'(spk_out_empty), 64'(1));
    chk("t5_full", 64'(spk_out_config_full), 64'(0));
    chk("t5_ovf", 64'(spk_out_ovf), 64'(0));
`ifdef SPK_OUT_CNT_EN
    chk("t5_cnt", 64'(spk_cnt), 64'(0));
`endif
    do_reset();

`ifdef SPK_OUT_CNT_EN
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 24'(i), 8'h55, 1'b0);
    step(1'b0, 1'b1, 24'h0, 8'h0, 1'b1);
    chk("t6_cnt7", 64'(spk_cnt), 64'(7));
    step(1'b0, 1'b1, 24'h0, 8'h0, 1'b1);
    chk("t6_cnt0", 64'(spk_cnt), 64'(0));
    step(1'b1, 1'b1, 24'h7, 8'h0, 1'b0);
    step(1'b1, 1'b1, 24'h8, 8'h0, 1'b1);
    chk("t6_cnt2", 64'(spk_cnt), 64'(2));
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
           24'($urandom), 8'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
